// File: rtl/core_periph_pkg.sv
// core_periph_pkg: command/response codes, FSM state encodings and STATUS word bit positions.
package core_periph_pkg;
  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_READ   = 2'b10;
  localparam logic [1:0] CMD_STATUS = 2'b11;
  localparam logic [1:0] RSP_ERR    = 2'b00;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam int STAT_IN_EMPTY = 0;
  localparam int STAT_OUT_FULL = 1;
  localparam int STAT_IN_CNT   = 8;
  localparam int STAT_OUT_CNT  = 16;
  localparam int STAT_OVERRUN  = 31;
endpackage

// File: rtl/core_peripheral_responder_if.sv
// core_peripheral_responder_if: core-side command/response port of the peripheral responder.
interface core_peripheral_responder_if #(parameter int DATA_WIDTH = 32);
  logic [1:0] to_peripheral;
  logic [DATA_WIDTH-1:0] to_peripheral_data;
  logic to_peripheral_valid;
  logic [1:0] from_peripheral;
  logic [DATA_WIDTH-1:0] from_peripheral_data;
  logic from_peripheral_valid;
  modport master (output to_peripheral, to_peripheral_data, to_peripheral_valid,
                  input  from_peripheral, from_peripheral_data, from_peripheral_valid);
  modport slave  (input  to_peripheral, to_peripheral_data, to_peripheral_valid,
                  output from_peripheral, from_peripheral_data, from_peripheral_valid);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign head = mem[rptr];
  always_ff @(posedge clock)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/core_peripheral_responder.sv
// core_peripheral_responder: services core WRITE/READ/STATUS commands against outbound/inbound stream FIFOs.
module core_peripheral_responder
  import core_periph_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic clock,
  input  logic reset,
  core_peripheral_responder_if.slave bus,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic tx_valid,
  input  logic tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic rx_valid,
  output logic rx_ready
);
  logic [0:0] state;
  logic [1:0] cmd_code;
  logic [DATA_WIDTH-1:0] cmd_data, in_head, status;
  logic [31:0] tmo_cnt;
  logic overrun, run;
  logic out_full, out_empty, in_full, in_empty;
  logic [CW-1:0] out_cnt, in_cnt;
  logic busy, start, drop, wr_svc, rd_svc, st_svc, svc, tmo;
  assign busy = state == ST_BUSY;
  assign start = ~busy & bus.to_peripheral_valid & (bus.to_peripheral != CMD_NOP);
  assign drop = busy & bus.to_peripheral_valid;
  assign wr_svc = busy & (cmd_code == CMD_WRITE) & ~out_full;
  assign rd_svc = busy & (cmd_code == CMD_READ) & ~in_empty;
  assign st_svc = busy & (cmd_code == CMD_STATUS);
  assign svc = wr_svc | rd_svc | st_svc;
  assign tmo = busy & ~svc & (TIMEOUT_CYCLES != 0) & (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign tx_valid = ~out_empty;
  // run holds rx_ready low until the first edge after reset release
  assign rx_ready = run & ~in_full;
  always_comb begin
    status = '0;
    status[STAT_IN_EMPTY] = in_empty;
    status[STAT_OUT_FULL] = out_full;
    status[STAT_IN_CNT +: 8] = 8'(in_cnt);
    status[STAT_OUT_CNT +: 8] = 8'(out_cnt);
    status[STAT_OVERRUN] = overrun;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      cmd_code <= CMD_NOP;
      cmd_data <= '0;
      tmo_cnt <= '0;
      overrun <= 1'b0;
      run <= 1'b0;
      bus.from_peripheral <= RSP_ERR;
      bus.from_peripheral_data <= '0;
      bus.from_peripheral_valid <= 1'b0;
    end else begin
      run <= 1'b1;
      if (start) begin
        state <= ST_BUSY;
        cmd_code <= bus.to_peripheral;
        cmd_data <= bus.to_peripheral_data;
        tmo_cnt <= '0;
      end else if (svc | tmo) state <= ST_IDLE;
      else if (busy) tmo_cnt <= tmo_cnt + 32'd1;
      overrun <= drop | (overrun & ~st_svc);
      bus.from_peripheral_valid <= svc | tmo;
      bus.from_peripheral <= svc ? cmd_code : RSP_ERR;
      bus.from_peripheral_data <= rd_svc ? in_head : st_svc ? status : '0;
    end
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_out (
    .clock(clock), .reset(reset), .push(wr_svc), .pop(tx_valid & tx_ready), .din(cmd_data),
    .head(tx_data), .full(out_full), .empty(out_empty), .count(out_cnt));
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_in (
    .clock(clock), .reset(reset), .push(rx_valid & rx_ready), .pop(rd_svc), .din(rx_data),
    .head(in_head), .full(in_full), .empty(in_empty), .count(in_cnt));
endmodule

// File: tb/tb_core_peripheral_responder.sv
// tb_core_peripheral_responder: directed checks of command service, blocking, timeout, overrun and reset.
module tb_core_peripheral_responder;
  logic clock = 1'b0;
  logic reset;
  logic [31:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, rx_ready;
  int n_cmp = 0, n_err = 0;
  int lat, hits;
  logic [1:0] rc;
  logic [31:0] rd;
  core_peripheral_responder_if #(.DATA_WIDTH(32)) bus();
  core_peripheral_responder #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .bus(bus), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [1:0] c, input logic [31:0] d);
    bus.to_peripheral = c;
    bus.to_peripheral_data = d;
    bus.to_peripheral_valid = 1'b1;
    tick();
    bus.to_peripheral_valid = 1'b0;
    bus.to_peripheral = 2'b00;
    bus.to_peripheral_data = '0;
  endtask
  task automatic wait_resp(output int l, output logic [1:0] c, output logic [31:0] d);
    l = 0;
    while (!bus.from_peripheral_valid && l < 20) begin
      tick();
      l++;
    end
    c = bus.from_peripheral;
    d = bus.from_peripheral_data;
  endtask
  task automatic issue(input logic [1:0] c, input logic [31:0] d, output int l,
                       output logic [1:0] oc, output logic [31:0] od);
    send(c, d);
    wait_resp(l, oc, od);
  endtask
  initial begin
    reset = 1'b0;
    bus.to_peripheral = 2'b00;
    bus.to_peripheral_data = '0;
    bus.to_peripheral_valid = 1'b0;
    tx_ready = 1'b0;
    rx_data = '0;
    rx_valid = 1'b0;
    #12;
    chk("rst_valid", bus.from_peripheral_valid, 0);
    chk("rst_code", bus.from_peripheral, 0);
    chk("rst_data", bus.from_peripheral_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 0);
    reset = 1'b1;
    tick();
    chk("rx_ready_after_rst", rx_ready, 1);
    // single WRITE with the sink ready: ack after one edge, word visible for one cycle
    tx_ready = 1'b1;
    issue(2'b01, 32'hA5A5_0001, lat, rc, rd);
    chk("wr_lat", lat, 1);
    chk("wr_code", rc, 2'b01);
    chk("wr_data", rd, 0);
    chk("wr_tx_valid", tx_valid, 1);
    chk("wr_tx_data", tx_data, 32'hA5A5_0001);
    tick();
    chk("wr_pulse_end", bus.from_peripheral_valid, 0);
    chk("wr_code_idle", bus.from_peripheral, 0);
    chk("wr_tx_drained", tx_valid, 0);
    tx_ready = 1'b0;
    // rx word then READ then STATUS
    rx_data = 32'h1234_5678;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    issue(2'b10, 0, lat, rc, rd);
    chk("rd_lat", lat, 1);
    chk("rd_code", rc, 2'b10);
    chk("rd_data", rd, 32'h1234_5678);
    issue(2'b11, 0, lat, rc, rd);
    chk("st_code", rc, 2'b11);
    chk("st_empty", rd, 32'h0000_0001);
    // fill the outbound FIFO with the sink stalled
    for (int i = 0; i < 8; i++) begin
      issue(2'b01, 32'h100 + i, lat, rc, rd);
      chk("fill_lat", lat, 1);
      chk("fill_code", rc, 2'b01);
    end
    send(2'b01, 32'h108);
    tick();
    chk("blocked_1", bus.from_peripheral_valid, 0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("blocked_2", bus.from_peripheral_valid, 0);
    tick();
    chk("unblock_valid", bus.from_peripheral_valid, 1);
    chk("unblock_code", bus.from_peripheral, 2'b01);
    issue(2'b11, 0, lat, rc, rd);
    chk("st_full", rd, 32'h0008_0003);
    chk("tx_head", tx_data, 32'h101);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", tx_data, 32'h100 + i);
      tick();
    end
    tx_ready = 1'b0;
    chk("drain_empty", tx_valid, 0);
    // READ on empty inbound FIFO times out after four busy edges
    issue(2'b10, 0, lat, rc, rd);
    chk("tmo_lat", lat, 4);
    chk("tmo_code", rc, 2'b00);
    chk("tmo_data", rd, 0);
    // word lands just before the fourth busy edge: service beats timeout
    send(2'b10, 0);
    tick();
    tick();
    rx_data = 32'hCAFE_0004;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("late_pending", bus.from_peripheral_valid, 0);
    tick();
    chk("late_valid", bus.from_peripheral_valid, 1);
    chk("late_code", bus.from_peripheral, 2'b10);
    chk("late_data", bus.from_peripheral_data, 32'hCAFE_0004);
    // command while BUSY is dropped and flagged
    send(2'b10, 0);
    send(2'b11, 0);
    wait_resp(lat, rc, rd);
    chk("drop_lat", lat, 3);
    chk("drop_code", rc, 2'b00);
    issue(2'b11, 0, lat, rc, rd);
    chk("ovr_set", rd, 32'h8000_0001);
    issue(2'b11, 0, lat, rc, rd);
    chk("ovr_clr", rd, 32'h0000_0001);
    // drop on the same edge as STATUS service keeps the flag
    bus.to_peripheral = 2'b11;
    bus.to_peripheral_valid = 1'b1;
    tick();
    tick();
    bus.to_peripheral_valid = 1'b0;
    bus.to_peripheral = 2'b00;
    chk("same_edge_valid", bus.from_peripheral_valid, 1);
    chk("same_edge_data", bus.from_peripheral_data, 32'h0000_0001);
    issue(2'b11, 0, lat, rc, rd);
    chk("same_edge_kept", rd, 32'h8000_0001);
    issue(2'b11, 0, lat, rc, rd);
    chk("same_edge_clr", rd, 32'h0000_0001);
    // reset while a READ is blocked, with a word parked in the outbound FIFO
    issue(2'b01, 32'hDEAD, lat, rc, rd);
    chk("pre_rst_wr", rc, 2'b01);
    send(2'b10, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", bus.from_peripheral_valid, 0);
    chk("mid_rst_code", bus.from_peripheral, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_rx_ready", rx_ready, 0);
    tick();
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.from_peripheral_valid) hits++;
    end
    chk("post_rst_no_resp", hits, 0);
    issue(2'b11, 0, lat, rc, rd);
    chk("post_rst_status", rd, 32'h0000_0001);
    chk("post_rst_tx_valid", tx_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/core_peripheral_responder.md
Name: core_peripheral_responder

Overview:
- Peripheral-side endpoint of the RISC_V_Core I/O port: consumes the core's to_peripheral_{code,data,valid} commands and returns from_peripheral_{code,data,valid} responses.
- Bridges the core to two byte-agnostic 32-bit streams: outbound tx (core writes) and inbound rx (core reads), each buffered in a synchronous FIFO.
- Used as the standard I/O target in core-level benches and in SoC top level.

Parameters:
DATA_WIDTH, 32, width of command/response data and stream words
FIFO_DEPTH, 8, entries per FIFO; power of two, 2..128
TIMEOUT_CYCLES, 0, cycles a blocked command waits before an error response; 0 means wait forever

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
to_peripheral  input  2  command code from core: 00 NOP, 01 WRITE, 10 READ, 11 STATUS
to_peripheral_data  input  DATA_WIDTH  WRITE payload; ignored for other codes
to_peripheral_valid  input  1  command strobe, one cycle per command
from_peripheral  output  2  response code: echoes command code; 00 means error/timeout
from_peripheral_data  output  DATA_WIDTH  READ data, STATUS word, else 0
from_peripheral_valid  output  1  one-cycle response pulse
tx_data  output  DATA_WIDTH  head of outbound FIFO (first-word fall-through)
tx_valid  output  1  outbound FIFO not empty
tx_ready  input  1  sink accepts tx_data when tx_valid&tx_ready
rx_data  input  DATA_WIDTH  inbound word
rx_valid  input  1  inbound word present
rx_ready  output  1  inbound FIFO not full

Behaviour:
- Reset (reset=0, async): FSM IDLE, both FIFOs empty, timeout counter 0, overrun flag 0; from_peripheral=00, from_peripheral_data=0, from_peripheral_valid=0, tx_valid=0, rx_ready=0 while asserted, 1 from the first edge after release.
- FSM states IDLE, BUSY. IDLE: to_peripheral_valid=1 with code!=00 sampled at edge k -> latch code/data, go BUSY. Code 00 with valid: ignored, no response.
- BUSY, evaluated each edge: WRITE serviceable if out FIFO not full -> push data; READ serviceable if in FIFO not empty -> pop; STATUS always serviceable. On service: register response (code echoed, data per type), go IDLE. Minimum latency: command at edge k, from_peripheral_valid high for exactly the cycle between edges k+1 and k+2.
- Response outputs are registered; from_peripheral_data=0 and from_peripheral=00 whenever valid=0.
- New command may be sampled at edge k+2 (during response pulse).
- to_peripheral_valid sampled in BUSY: command dropped, overrun flag set (sticky), no response.
- Timeout: counter counts edges in BUSY, cleared on entering BUSY. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES without service: response code 00, data 0, go IDLE, no FIFO change. Service and timeout on same edge: service wins.
- STATUS word: [0] in FIFO empty, [1] out FIFO full, [15:8] in count, [23:16] out count (zero-extended), [31] overrun; other bits 0. Overrun cleared on the edge the STATUS response is registered; a drop on that same edge keeps it set.
- Outbound FIFO: pop on tx_valid&tx_ready; push from WRITE; simultaneous push/pop legal, count unchanged.
- Inbound FIFO: push on rx_valid&rx_ready; pop from READ; simultaneous legal. When full, rx_ready=0 even if a READ pop occurs that edge.
- Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Reset mid-command: in-flight command discarded, no response.

Decomposition:
- Package core_periph_pkg: command/response code constants (NOP, WRITE, READ, STATUS, ERR), FSM state enum, STATUS bit-position constants.
- One sub-module: sync_fifo (DATA_WIDTH, FIFO_DEPTH; push, pop, full, empty, count, FWFT head), instantiated twice.

Test Plan:
- WRITE 0xA5A5_0001 at edge k, tx_ready=1 -> from_peripheral=01, valid pulse in cycle k+1..k+2; tx_data=0xA5A5_0001, tx_valid for one cycle.
- rx pushes 0x1234_5678, then READ -> response code 10, data 0x1234_5678; STATUS next -> bit0=1, counts 0.
- tx_ready=0, nine WRITEs (DEPTH 8) -> eight acks; ninth blocks; raise tx_ready -> ninth acked one edge later, STATUS out count=8.
- TIMEOUT_CYCLES=4, READ with in FIFO empty -> code 00, data 0 after 4 BUSY edges; rx word arriving on 4th edge -> READ served instead.
- Command asserted while BUSY -> no response, STATUS bit31=1; second STATUS -> bit31=0.
- reset low while READ blocked -> outputs 0, no response after release; FIFOs empty.
